// File: rtl/gray_pkg.sv
// Shared state encoding, luma coefficients and luma helper for the RGB-to-gray reader.
// GRAY_ROUND_EN selects round-to-nearest luma; otherwise the weighted sum is truncated.
package gray_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_R = 3'd1,
        GET_G = 3'd2,
        GET_B = 3'd3,
        CALC  = 3'd4,
        EMIT  = 3'd5,
        FIN   = 3'd6
    } state_e;

    localparam logic [15:0] COEF_R  = 16'd77;
    localparam logic [15:0] COEF_G  = 16'd150;
    localparam logic [15:0] COEF_B  = 16'd29;
    localparam logic [15:0] ROUND_K = 16'd128;

    // Coefficients sum to 256, so the high byte of the 16-bit sum is the luma and never overflows.
    function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [15:0] sum;
        sum = COEF_R * {8'd0, r} + COEF_G * {8'd0, g} + COEF_B * {8'd0, b};
`ifdef GRAY_ROUND_EN
        sum = sum + ROUND_K;
`endif
        return sum[15:8];
    endfunction

endpackage

// File: rtl/gray_byte_fifo.sv
// Small first-word-fall-through byte FIFO used as the skid buffer in front of the gray reader.
// Push while full and pop while empty are ignored; simultaneous push and pop keep the count.
module gray_byte_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage array write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rgb_gray_reader.sv
// Consumes R,G,B bytes from the frame store, throttles it with pause, and emits one luma pixel per triplet.
// Build option GRAY_ROUND_EN (see gray_pkg) switches the luma from truncation to round-to-nearest.
module rgb_gray_reader
    import gray_pkg::*;
#(
    parameter int N            = 5,
    parameter int M            = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int PAUSE_THRESH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    output logic       pause,
    output logic [7:0] gray_out,
    output logic       gray_valid,
    input  logic       gray_ready,
    output logic       busy,
    output logic       done,
    output logic       ovf_err
);

    localparam int NPIX = N * M;
    localparam int PCW  = $clog2(NPIX + 1);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;

    state_e         state_r;
    state_e         state_nx;
    logic [7:0]     r_r;
    logic [7:0]     g_r;
    logic [7:0]     b_r;
    logic [7:0]     gray_r;
    logic           gray_valid_r;
    logic           busy_r;
    logic           done_r;
    logic           ovf_r;
    logic [PCW-1:0] pix_cnt_r;
    logic           last_pix_s;
    logic           fifo_push_s;
    logic           fifo_pop_s;
    logic [7:0]     fifo_dout_s;
    logic [CW-1:0]  fifo_count_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;

    // Bytes are accepted in every state, including IDLE and while pause is high.
    assign fifo_push_s = pix_valid & ~fifo_full_s;
    assign last_pix_s  = (pix_cnt_r == PCW'(NPIX - 1));

    gray_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .din   (pix_in),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // The store reacts one cycle late, so pause must come straight from the registered count.
    assign pause      = (state_r != IDLE) && (fifo_count_s >= CW'(PAUSE_THRESH));
    assign gray_out   = gray_r;
    assign gray_valid = gray_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign ovf_err    = ovf_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state and FIFO pop decode.
    always_comb begin
        state_nx   = state_r;
        fifo_pop_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) state_nx = GET_R;
                else       state_nx = IDLE;
            end
            GET_R: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    state_nx   = GET_G;
                end else begin
                    state_nx   = GET_R;
                end
            end
            GET_G: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    state_nx   = GET_B;
                end else begin
                    state_nx   = GET_G;
                end
            end
            GET_B: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    state_nx   = CALC;
                end else begin
                    state_nx   = GET_B;
                end
            end
            CALC: state_nx = EMIT;
            EMIT: begin
                if (gray_ready) state_nx = last_pix_s ? FIN : GET_R;
                else            state_nx = EMIT;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Colour capture, luma computation, output handshake and pixel counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r          <= 8'd0;
            g_r          <= 8'd0;
            b_r          <= 8'd0;
            gray_r       <= 8'd0;
            gray_valid_r <= 1'b0;
            pix_cnt_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) pix_cnt_r <= '0;
                end
                GET_R: begin
                    if (fifo_pop_s) r_r <= fifo_dout_s;
                end
                GET_G: begin
                    if (fifo_pop_s) g_r <= fifo_dout_s;
                end
                GET_B: begin
                    if (fifo_pop_s) b_r <= fifo_dout_s;
                end
                CALC: begin
                    gray_r       <= luma(r_r, g_r, b_r);
                    gray_valid_r <= 1'b1;
                end
                EMIT: begin
                    if (gray_ready) begin
                        gray_valid_r <= 1'b0;
                        pix_cnt_r    <= pix_cnt_r + PCW'(1);
                    end
                end
                FIN:     pix_cnt_r <= '0;
                default: pix_cnt_r <= pix_cnt_r;
            endcase
        end
    end

    // Status flags; a dropped byte wins over a simultaneous clearing start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            busy_r <= (state_nx != IDLE);
            done_r <= (state_nx == FIN);
            if (pix_valid && fifo_full_s) begin
                ovf_r <= 1'b1;
            end else if ((state_r == IDLE) && start) begin
                ovf_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rgb_gray_reader.sv
// Self-checking bench for rgb_gray_reader: store model with delayed pause reaction,
// luma scoreboard from the plain weighted-sum formula, table vectors and reset/start corner cases.
module tb_rgb_gray_reader;

    localparam int N    = 5;
    localparam int M    = 5;
    localparam int NPIX = N * M;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       pause;
    logic [7:0] gray_out;
    logic       gray_valid;
    logic       gray_ready;
    logic       busy;
    logic       done;
    logic       ovf_err;

    rgb_gray_reader #(.N(N), .M(M), .FIFO_DEPTH(4), .PAUSE_THRESH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pause      (pause),
        .gray_out   (gray_out),
        .gray_valid (gray_valid),
        .gray_ready (gray_ready),
        .busy       (busy),
        .done       (done),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         exp_t;
        int         exp_r;
    } vec_t;

    vec_t       tab [4];
    int         total = 0;
    int         bad = 0;
    logic [7:0] send_q [$];
    logic [7:0] sent_q [$];
    logic [7:0] obs [$];
    int         store_mode = 0;  // 0: honour pause, 1: ignore pause, 2: honour pause with random gaps
    int         ready_mode = 0;  // 0: always ready, 1: random, 2: never ready
    logic       pause_d = 1'b0;
    logic       exp_done = 1'b0;
    logic       start_req = 1'b0;
    int         acc_cnt = 0;
    int         done_seen = 0;

    function automatic int ref_gray(input int r, input int g, input int b);
        int s;
        s = 77 * r + 150 * g + 29 * b;
`ifdef GRAY_ROUND_EN
        s = s + 128;
`endif
        return s / 256;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pause"},      {31'd0, pause},      32'd0);
        check({tag, "_gray_out"},   {24'd0, gray_out},   32'd0);
        check({tag, "_gray_valid"}, {31'd0, gray_valid}, 32'd0);
        check({tag, "_busy"},       {31'd0, busy},       32'd0);
        check({tag, "_done"},       {31'd0, done},       32'd0);
        check({tag, "_ovf_err"},    {31'd0, ovf_err},    32'd0);
    endtask

    // One cycle: check done, drive store and downstream, score any handshake due at the next edge.
    task automatic step();
        int r;
        int g;
        int b;
        @(negedge clk);
        if (done === 1'b1) done_seen++;
        check("done_pulse", {31'd0, done}, {31'd0, exp_done});
        exp_done  = 1'b0;
        start     = start_req;
        start_req = 1'b0;
        if (send_q.size() > 0 &&
            (store_mode == 1 || (!pause_d && (store_mode == 0 || $urandom_range(0, 3) != 0)))) begin
            pix_valid = 1'b1;
            pix_in    = send_q.pop_front();
            sent_q.push_back(pix_in);
        end else begin
            pix_valid = 1'b0;
            pix_in    = 8'($urandom);
        end
        pause_d = pause;
        case (ready_mode)
            0:       gray_ready = 1'b1;
            1:       gray_ready = 1'($urandom_range(0, 1));
            default: gray_ready = 1'b0;
        endcase
        if (gray_valid === 1'b1 && gray_ready) begin
            obs.push_back(gray_out);
            if (sent_q.size() >= 3) begin
                r = int'(sent_q.pop_front());
                g = int'(sent_q.pop_front());
                b = int'(sent_q.pop_front());
                check("gray_model", {24'd0, gray_out}, ref_gray(r, g, b));
            end else begin
                check("gray_underflow", sent_q.size(), 32'd3);
            end
            acc_cnt++;
            if (acc_cnt == NPIX) begin
                acc_cnt  = 0;
                exp_done = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        start_req  = 1'b0;
        pix_valid  = 1'b0;
        pix_in     = 8'd0;
        gray_ready = 1'b0;
        send_q.delete();
        sent_q.delete();
        obs.delete();
        acc_cnt  = 0;
        exp_done = 1'b0;
        pause_d  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_random(input int npix);
        for (int i = 0; i < 3 * npix; i++) send_q.push_back(8'($urandom));
    endtask

    task automatic run_frame(input string tag, input int budget, input bit pulse);
        int d0;
        d0 = done_seen;
        for (int i = 0; i < budget; i++) begin
            if (pulse && i > 2 && (i % 7) == 3) start_req = 1'b1;
            step();
            if (done_seen != d0) break;
        end
        check({tag, "_done_count"}, done_seen - d0, 32'd1);
        check({tag, "_pixels"}, obs.size(), NPIX);
        step();
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        tab[0] = '{8'd255, 8'd0,   8'd0,   76,  77};
        tab[1] = '{8'd0,   8'd255, 8'd0,   149, 149};
        tab[2] = '{8'd0,   8'd0,   8'd255, 28,  29};
        tab[3] = '{8'd255, 8'd255, 8'd255, 255, 255};

        // Reset state
        rst_n = 1'b0;
        do_reset();
        check_zero_outputs("reset");

        // Uniform grey frame, always ready
        store_mode = 0;
        ready_mode = 0;
        for (int i = 0; i < 3 * NPIX; i++) send_q.push_back(8'd100);
        start_req = 1'b1;
        run_frame("t1", 2000, 1'b0);
        for (int i = 0; i < obs.size(); i++) check("t1_gray100", {24'd0, obs[i]}, 32'd100);

        // Table vectors at the head of a random frame
        obs.delete();
        store_mode = 2;
        ready_mode = 1;
        for (int i = 0; i < 4; i++) begin
            send_q.push_back(tab[i].r);
            send_q.push_back(tab[i].g);
            send_q.push_back(tab[i].b);
        end
        load_random(NPIX - 4);
        start_req = 1'b1;
        run_frame("t2", 4000, 1'b0);
        for (int i = 0; i < 4; i++) begin
`ifdef GRAY_ROUND_EN
            check("t2_table", {24'd0, obs[i]}, tab[i].exp_r);
`else
            check("t2_table", {24'd0, obs[i]}, tab[i].exp_t);
`endif
        end

        // Downstream stalls: FIFO must settle at three bytes with no overflow
        obs.delete();
        store_mode = 0;
        ready_mode = 2;
        load_random(NPIX);
        start_req = 1'b1;
        repeat (25) step();
        check("t3_pause_high", {31'd0, pause}, 32'd1);
        check("t3_bytes_sent", 3 * NPIX - send_q.size(), 32'd6);
        check("t3_valid_held", {31'd0, gray_valid}, 32'd1);
        check("t3_no_ovf", {31'd0, ovf_err}, 32'd0);
        ready_mode = 1;
        run_frame("t3", 4000, 1'b0);
        check("t3_no_ovf_end", {31'd0, ovf_err}, 32'd0);

        // Store ignores pause in IDLE: fill to 4, fifth byte overflows
        obs.delete();
        store_mode = 1;
        ready_mode = 2;
        for (int i = 0; i < 6; i++) send_q.push_back(8'(i + 1));
        repeat (5) step();
        check("t4_full_no_ovf", {31'd0, ovf_err}, 32'd0);
        step();
        check("t4_ovf_set", {31'd0, ovf_err}, 32'd1);
        check("t4_idle_pause", {31'd0, pause}, 32'd0);
        repeat (5) step();
        check("t4_ovf_held", {31'd0, ovf_err}, 32'd1);
        start_req = 1'b1;
        repeat (2) step();
        check("t4_ovf_cleared", {31'd0, ovf_err}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd1);
        do_reset();

        // Asynchronous reset in the middle of pixel 12, then a clean frame
        store_mode = 0;
        ready_mode = 0;
        load_random(NPIX);
        start_req = 1'b1;
        for (int i = 0; i < 1000 && acc_cnt < 12; i++) step();
        check("t5_reached_12", acc_cnt, 32'd12);
        repeat (2) step();
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("t5_async");
        do_reset();
        store_mode = 2;
        ready_mode = 1;
        load_random(NPIX);
        start_req = 1'b1;
        run_frame("t5", 4000, 1'b0);

        // Start pulses while busy are ignored
        obs.delete();
        store_mode = 2;
        ready_mode = 0;
        load_random(NPIX);
        start_req = 1'b1;
        run_frame("t6", 4000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
